// File: rtl/gpr_pkg.sv
// Shared defaults and helpers for the pipelined-datapath register file.
package gpr_pkg;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NREAD  = 2;
    localparam int DEF_PEND_W = 2;
    localparam int ZERO_REG   = 0;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/gpr_pend_ctr.sv
// Saturating pending-writer counter for one register; inc and dec together cancel.
module gpr_pend_ctr
    import gpr_pkg::*;
#(
    parameter int PEND_W = DEF_PEND_W
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              at_max,
    output logic              nonzero
);
    logic [PEND_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && !dec && !at_max) begin
            r_count <= r_count + PEND_W'(1);
        end else if (dec && !inc && nonzero) begin
            r_count <= r_count - PEND_W'(1);
        end
    end

    assign count   = r_count;
    assign at_max  = &r_count;
    assign nonzero = |r_count;
endmodule

// File: rtl/gpr_file.sv
// Multi-port GPR file with hardwired zero register, write-to-read bypass and
// per-register pending-writer scoreboard for decode-stage stalls.
module gpr_file
    import gpr_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NREAD  = DEF_NREAD,
    parameter int PEND_W = DEF_PEND_W,
    parameter int BYPASS = 1,
    localparam int AW    = addr_w(DEPTH)
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*WIDTH-1:0] rd_data,
    output logic [NREAD-1:0]       rd_pending,
    input  logic                   we,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   claim_en,
    input  logic [AW-1:0]          claim_addr,
    output logic                   claim_ready,
    output logic                   busy_any
);
    logic [WIDTH-1:0]  r_regs [DEPTH];
    logic [PEND_W-1:0] w_count [DEPTH];
    logic [DEPTH-1:0]  w_at_max;
    logic [DEPTH-1:0]  w_nonzero;
    logic              w_claim_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_regs[k] <= '0;
            end
        end else if (we && wr_addr != AW'(ZERO_REG)) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // A full counter can still take a claim when a release lands on it this cycle.
    assign claim_ready = !(w_at_max[claim_addr] && !(we && wr_addr == claim_addr));
    assign w_claim_ok  = claim_en && claim_ready;
    assign busy_any    = |w_nonzero;

    assign w_count[ZERO_REG]   = '0;
    assign w_at_max[ZERO_REG]  = 1'b0;
    assign w_nonzero[ZERO_REG] = 1'b0;

    for (genvar r = 1; r < DEPTH; r++) begin : g_pc
        gpr_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
            .clk     (clk),
            .reset   (reset),
            .inc     (w_claim_ok && claim_addr == AW'(r)),
            .dec     (we && wr_addr == AW'(r)),
            .count   (w_count[r]),
            .at_max  (w_at_max[r]),
            .nonzero (w_nonzero[r])
        );
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_fwd;

        assign w_ra  = rd_addr[i*AW +: AW];
        assign w_fwd = (BYPASS != 0) && we && (wr_addr == w_ra);
        assign rd_data[i*WIDTH +: WIDTH] = (w_ra == AW'(ZERO_REG)) ? '0 :
                                           w_fwd ? wr_data : r_regs[w_ra];
        assign rd_pending[i] = (w_count[w_ra] != '0);
    end
endmodule

// File: tb/tb_gpr_file.sv
// Bench for gpr_file: 4-port bypassing instance plus a 1-port non-bypass twin.
module tb_gpr_file;
    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*W-1:0]   rd_data;
    logic [NR-1:0]     rd_pending;
    logic              we;
    logic [AW-1:0]     wr_addr;
    logic [W-1:0]      wr_data;
    logic              claim_en;
    logic [AW-1:0]     claim_addr;
    logic              claim_ready, busy_any;
    logic [AW-1:0]     rd_addr_nb;
    logic [W-1:0]      rd_data_nb;
    logic [0:0]        rd_pending_nb;
    logic              claim_ready_nb, busy_any_nb;

    always #5 clk = ~clk;
    assign rd_addr_nb = rd_addr[AW-1:0];

    gpr_file #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .PEND_W(2), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_pending(rd_pending), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .claim_ready(claim_ready),
        .busy_any(busy_any)
    );

    gpr_file #(.WIDTH(W), .DEPTH(D), .NREAD(1), .PEND_W(2), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_nb), .rd_data(rd_data_nb),
        .rd_pending(rd_pending_nb), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .claim_ready(claim_ready_nb),
        .busy_any(busy_any_nb)
    );

    typedef struct packed {
        logic               we;
        logic [4:0]         wa;
        logic [31:0]        wd;
        logic               ce;
        logic [4:0]         ca;
        logic [3:0][4:0]    ra;
        logic [3:0][31:0]   erd;
        logic [3:0]         ep;
        logic               ecr;
        logic               ebusy;
        logic [31:0]        enb;
    } vec_t;

    typedef struct packed {
        logic [3:0][31:0] rd;
        logic [3:0]       pend;
        logic             cr;
        logic             busy;
        logic [31:0]      nb;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl [23];

    function automatic vec_t mk(input logic we_i, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ce, input logic [4:0] ca,
                                input logic [4:0] a0, input logic [4:0] a1,
                                input logic [4:0] a2, input logic [4:0] a3,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3,
                                input logic [3:0] ep, input logic ecr, input logic ebusy,
                                input logic [31:0] enb);
        vec_t v;
        v.we = we_i; v.wa = wa; v.wd = wd; v.ce = ce; v.ca = ca;
        v.ra[0] = a0; v.ra[1] = a1; v.ra[2] = a2; v.ra[3] = a3;
        v.erd[0] = e0; v.erd[1] = e1; v.erd[2] = e2; v.erd[3] = e3;
        v.ep = ep; v.ecr = ecr; v.ebusy = ebusy; v.enb = enb;
        return v;
    endfunction

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.rd = v.erd; e.pend = v.ep; e.cr = v.ecr; e.busy = v.ebusy; e.nb = v.enb;
        sb.push_back(e);
    endtask

    task automatic drive(input vec_t v);
        we = v.we; wr_addr = v.wa; wr_data = v.wd;
        claim_en = v.ce; claim_addr = v.ca; rd_addr = v.ra;
        push_exp(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got %h, want %h", nm, idx, act, exp);
        end
    endtask

    task automatic check(input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard #%0d: got empty queue, want an entry", idx);
            return;
        end
        e = sb.pop_front();
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("rd_data[%0d]", p), idx, rd_data[p*W +: W], e.rd[p]);
        end
        chk("rd_pending", idx, 32'(rd_pending), 32'(e.pend));
        chk("claim_ready", idx, 32'(claim_ready), 32'(e.cr));
        chk("busy_any", idx, 32'(busy_any), 32'(e.busy));
        chk("nb_rd_data", idx, rd_data_nb, e.nb);
        chk("nb_rd_pending", idx, 32'(rd_pending_nb), 32'(e.pend[0]));
        chk("nb_claim_ready", idx, 32'(claim_ready_nb), 32'(e.cr));
        chk("nb_busy_any", idx, 32'(busy_any_nb), 32'(e.busy));
    endtask

    initial begin
        //              we wa  wd            ce ca  ra0..ra3      rd0..rd3 expected                       pend     cr busy nb
        tbl[0]  = mk(0, 0, 0,            0, 0,  0, 0, 0, 0,  0, 0, 0, 0,                         4'b0000, 1, 0, 0);
        tbl[1]  = mk(1, 0, 5,            1, 0,  0, 0, 0, 0,  0, 0, 0, 0,                         4'b0000, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0,            0, 0,  0, 0, 0, 0,  0, 0, 0, 0,                         4'b0000, 1, 0, 0);
        tbl[3]  = mk(1, 4, 5,            0, 0,  4, 0, 0, 0,  5, 0, 0, 0,                         4'b0000, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0,            0, 0,  4, 0, 0, 0,  5, 0, 0, 0,                         4'b0000, 1, 0, 5);
        tbl[5]  = mk(1, 1, 1,            0, 0,  1, 2, 3, 4,  1, 0, 0, 5,                         4'b0000, 1, 0, 0);
        tbl[6]  = mk(1, 2, 2,            0, 0,  1, 2, 3, 4,  1, 2, 0, 5,                         4'b0000, 1, 0, 1);
        tbl[7]  = mk(1, 3, 3,            0, 0,  1, 2, 3, 4,  1, 2, 3, 5,                         4'b0000, 1, 0, 1);
        tbl[8]  = mk(1, 4, 4,            0, 0,  4, 3, 2, 1,  4, 3, 2, 1,                         4'b0000, 1, 0, 5);
        tbl[9]  = mk(0, 0, 0,            0, 0,  4, 3, 2, 1,  4, 3, 2, 1,                         4'b0000, 1, 0, 4);
        tbl[10] = mk(1, 3, 32'h33,       0, 0,  3, 3, 3, 3,  32'h33, 32'h33, 32'h33, 32'h33,     4'b0000, 1, 0, 3);
        tbl[11] = mk(0, 0, 0,            0, 0,  3, 3, 3, 3,  32'h33, 32'h33, 32'h33, 32'h33,     4'b0000, 1, 0, 32'h33);
        tbl[12] = mk(0, 0, 0,            1, 7,  7, 0, 0, 0,  0, 0, 0, 0,                         4'b0000, 1, 0, 0);
        tbl[13] = mk(0, 0, 0,            1, 7,  7, 0, 0, 0,  0, 0, 0, 0,                         4'b0001, 1, 1, 0);
        tbl[14] = mk(0, 0, 0,            1, 7,  7, 0, 0, 0,  0, 0, 0, 0,                         4'b0001, 1, 1, 0);
        tbl[15] = mk(0, 0, 0,            1, 7,  7, 0, 0, 0,  0, 0, 0, 0,                         4'b0001, 0, 1, 0);
        tbl[16] = mk(1, 7, 32'h77,       1, 7,  7, 0, 0, 0,  32'h77, 0, 0, 0,                    4'b0001, 1, 1, 0);
        tbl[17] = mk(1, 7, 32'h71,       0, 0,  7, 0, 0, 0,  32'h71, 0, 0, 0,                    4'b0001, 1, 1, 32'h77);
        tbl[18] = mk(1, 7, 32'h72,       0, 0,  7, 0, 0, 0,  32'h72, 0, 0, 0,                    4'b0001, 1, 1, 32'h71);
        tbl[19] = mk(1, 7, 32'h73,       0, 0,  7, 0, 0, 0,  32'h73, 0, 0, 0,                    4'b0001, 1, 1, 32'h72);
        tbl[20] = mk(0, 0, 0,            0, 0,  7, 0, 0, 0,  32'h73, 0, 0, 0,                    4'b0000, 1, 0, 32'h73);
        tbl[21] = mk(1, 9, 32'h99,       0, 0,  9, 0, 0, 0,  32'h99, 0, 0, 0,                    4'b0000, 1, 0, 0);
        tbl[22] = mk(0, 0, 0,            0, 0,  9, 0, 0, 0,  32'h99, 0, 0, 0,                    4'b0000, 1, 0, 32'h99);

        reset = 1'b1; we = 0; wr_addr = 0; wr_data = 0;
        claim_en = 0; claim_addr = 0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check(i);
            @(posedge clk);
            #1;
        end

        // Reset mid-cycle: a stored write and a live claim must vanish before any edge.
        drive(mk(1, 4, 32'hDEADBEEF, 1, 5,  4, 5, 3, 0,  32'hDEADBEEF, 0, 32'h33, 0,  4'b0000, 1, 0, 4));
        @(negedge clk);
        check(100);
        @(posedge clk);
        #1;
        drive(mk(0, 0, 0, 0, 5,  4, 5, 3, 0,  32'hDEADBEEF, 0, 32'h33, 0,  4'b0010, 1, 1, 32'hDEADBEEF));
        #2 check(101);
        #1 reset = 1'b1;
        push_exp(mk(0, 0, 0, 0, 5,  4, 5, 3, 0,  0, 0, 0, 0,  4'b0000, 1, 0, 0));
        #1 check(102);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(mk(0, 0, 0, 0, 0,  4, 5, 7, 9,  0, 0, 0, 0,  4'b0000, 1, 0, 0));
        @(negedge clk);
        check(103);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
